// File: rtl/mic1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mic1_pkg
// Brief    : Shared widths, ALU control codes and sequencer states for MIC-1.
// Revision : 1.0 - initial release
// ============================================================================
package mic1_pkg;

    localparam int MPC_W = 9;
    localparam int MBR_W = 8;

    // {F0,F1,ENA,ENB,INVA,INC} encodings of the sixteen legal ALU operations
    typedef enum logic [5:0] {
        ALU_A          = 6'b011000,
        ALU_B          = 6'b010100,
        ALU_NOT_A      = 6'b011010,
        ALU_NOT_B      = 6'b101100,
        ALU_A_PLUS_B   = 6'b111100,
        ALU_A_PLUS_B_1 = 6'b111101,
        ALU_A_PLUS_1   = 6'b111001,
        ALU_B_PLUS_1   = 6'b110101,
        ALU_B_MINUS_A  = 6'b111111,
        ALU_B_MINUS_1  = 6'b110110,
        ALU_NEG_A      = 6'b111011,
        ALU_A_AND_B    = 6'b001100,
        ALU_A_OR_B     = 6'b011100,
        ALU_ZERO       = 6'b010000,
        ALU_ONE        = 6'b110001,
        ALU_MINUS_ONE  = 6'b110010
    } alu_code_e;

    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_STALL = 2'd1,
        SEQ_HALT  = 2'd2,
        SEQ_ERROR = 2'd3
    } seq_state_e;

endpackage : mic1_pkg
`default_nettype wire

// File: rtl/mic1_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mic1_sequencer_if
// Brief    : Microinstruction fields, fetch handshake and sequencer status.
// Revision : 1.0 - initial release
// ============================================================================
interface mic1_sequencer_if;
    import mic1_pkg::*;

    logic [MPC_W-1:0] next_addr;
    logic             jmpc;
    logic             jamn;
    logic             jamz;
    logic [5:0]       alu_ctrl;
    logic             alu_n;
    logic             alu_z;
    logic             fetch;
    logic [MBR_W-1:0] mbr;
    logic             mbr_valid;
    logic [MPC_W-1:0] mpc;
    logic             n_ff;
    logic             z_ff;
    logic             stall;
    logic             halted;
    logic             err;

    modport master (
        output next_addr, jmpc, jamn, jamz, alu_ctrl, alu_n, alu_z,
        output fetch, mbr, mbr_valid,
        input  mpc, n_ff, z_ff, stall, halted, err
    );

    modport slave (
        input  next_addr, jmpc, jamn, jamz, alu_ctrl, alu_n, alu_z,
        input  fetch, mbr, mbr_valid,
        output mpc, n_ff, z_ff, stall, halted, err
    );

endinterface : mic1_sequencer_if
`default_nettype wire

// File: rtl/mic1_alu_ctrl_check.sv
`default_nettype none
// ============================================================================
// Module   : mic1_alu_ctrl_check
// Brief    : Combinational legality decode of the 6-bit ALU control field.
// Revision : 1.0 - initial release
// ============================================================================
module mic1_alu_ctrl_check
    import mic1_pkg::*;
(
    input  wire logic [5:0] alu_ctrl,
    output logic            legal
);

    always_comb begin
        legal = 1'b0;
        case (alu_ctrl)
            ALU_A, ALU_B, ALU_NOT_A, ALU_NOT_B,
            ALU_A_PLUS_B, ALU_A_PLUS_B_1, ALU_A_PLUS_1, ALU_B_PLUS_1,
            ALU_B_MINUS_A, ALU_B_MINUS_1, ALU_NEG_A, ALU_A_AND_B,
            ALU_A_OR_B, ALU_ZERO, ALU_ONE, ALU_MINUS_ONE: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
    end

endmodule : mic1_alu_ctrl_check
`default_nettype wire

// File: rtl/mic1_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mic1_sequencer
// Brief    : MIC-1 microprogram sequencer with MBR-fetch interlock and
//            illegal-ALU-code trap. Define MIC1_SEQ_HALT_EN to enable HALT.
// Revision : 1.0 - initial release
// ============================================================================
module mic1_sequencer
    import mic1_pkg::*;
#(
    parameter logic [MPC_W-1:0] RESET_MPC = 9'h000,
    parameter logic [MPC_W-1:0] HALT_ADDR = 9'h1FF
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mic1_sequencer_if.slave bus
);

    seq_state_e       r_state;
    seq_state_e       w_next_state;
    logic [MPC_W-1:0] r_mpc;
    logic             r_n_ff;
    logic             r_z_ff;
    logic             r_pending;
    logic [MPC_W-1:0] w_next_mpc;
    logic             w_legal;
    logic             w_dep_stall;
    logic             w_stall;
    logic             w_load;

    mic1_alu_ctrl_check u_alu_check (
        .alu_ctrl (bus.alu_ctrl),
        .legal    (w_legal)
    );

    assign w_next_mpc[MPC_W-1]   = bus.next_addr[MPC_W-1]
                                 | (bus.jamn & bus.alu_n)
                                 | (bus.jamz & bus.alu_z);
    assign w_next_mpc[MBR_W-1:0] = bus.next_addr[MBR_W-1:0]
                                 | (bus.jmpc ? bus.mbr : {MBR_W{1'b0}});

    // A completing fetch in the same cycle lets jmpc consume mbr directly.
    assign w_dep_stall = (bus.jmpc | bus.fetch) & r_pending & ~bus.mbr_valid;

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_load       = 1'b0;
        if (!rst) begin
            case (r_state)
                SEQ_RUN, SEQ_STALL: begin
                    w_stall = w_dep_stall;
                    if (!w_legal) begin
                        w_next_state = SEQ_ERROR;
                    end else if (w_dep_stall) begin
                        w_next_state = SEQ_STALL;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = SEQ_RUN;
`ifdef MIC1_SEQ_HALT_EN
                        if (w_next_mpc == HALT_ADDR) begin
                            w_next_state = SEQ_HALT;
                        end
`endif
                    end
                end
                default: w_stall = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SEQ_RUN;
            r_mpc     <= RESET_MPC;
            r_n_ff    <= 1'b0;
            r_z_ff    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_mpc  <= w_next_mpc;
                r_n_ff <= bus.alu_n;
                r_z_ff <= bus.alu_z;
            end
            // A newly accepted fetch wins over a completion in the same cycle.
            if (w_load && bus.fetch) begin
                r_pending <= 1'b1;
            end else if (bus.mbr_valid) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.mpc   = r_mpc;
    assign bus.n_ff  = r_n_ff;
    assign bus.z_ff  = r_z_ff;
    assign bus.stall = w_stall;
    assign bus.err   = (r_state == SEQ_ERROR);
`ifdef MIC1_SEQ_HALT_EN
    assign bus.halted = (r_state == SEQ_HALT);
`else
    assign bus.halted = 1'b0;
`endif

endmodule : mic1_sequencer
`default_nettype wire

// File: tb/tb_mic1_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic1_sequencer
// Brief    : Directed vector table plus hand-written stall/error/halt sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic1_sequencer;

`ifdef MIC1_SEQ_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    mic1_sequencer_if bus ();

    mic1_sequencer #(
        .RESET_MPC (9'h000),
        .HALT_ADDR (9'h1FF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] next_addr;
        logic       jmpc;
        logic       jamn;
        logic       jamz;
        logic       alu_n;
        logic       alu_z;
        logic [7:0] mbr;
        logic [8:0] exp_mpc;
        logic       exp_n;
        logic       exp_z;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.next_addr = 9'h000;
        bus.jmpc      = 1'b0;
        bus.jamn      = 1'b0;
        bus.jamz      = 1'b0;
        bus.alu_ctrl  = 6'b011000;
        bus.alu_n     = 1'b0;
        bus.alu_z     = 1'b0;
        bus.fetch     = 1'b0;
        bus.mbr       = 8'h00;
        bus.mbr_valid = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        // next_addr jmpc jamn jamz n z mbr -> mpc n_ff z_ff
        vecs[0] = '{9'h055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'h055, 1'b0, 1'b0};
        vecs[1] = '{9'h012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 9'h112, 1'b0, 1'b1};
        vecs[2] = '{9'h012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9'h012, 1'b0, 1'b0};
        vecs[3] = '{9'h034, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'h134, 1'b1, 1'b0};
        vecs[4] = '{9'h034, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 9'h034, 1'b0, 1'b1};
        vecs[5] = '{9'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 9'h100, 1'b0, 1'b1};
        vecs[6] = '{9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 9'h0A5, 1'b0, 1'b0};
        vecs[7] = '{9'h00F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h50, 9'h05F, 1'b1, 1'b1};
        vecs[8] = '{9'h020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 9'h120, 1'b1, 1'b0};

        // Reset with a live next_addr, then release
        idle_inputs();
        rst = 1'b1;
        bus.next_addr = 9'h055;
        step();
        check("rst_mpc",    32'(bus.mpc),    32'h000);
        check("rst_n_ff",   32'(bus.n_ff),   32'h0);
        check("rst_z_ff",   32'(bus.z_ff),   32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_err",    32'(bus.err),    32'h0);
        check("rst_stall",  32'(bus.stall),  32'h0);
        rst = 1'b0;
        step();
        check("post_rst_mpc", 32'(bus.mpc), 32'h055);

        // Single-cycle RUN vectors
        for (int i = 0; i < 9; i++) begin
            bus.next_addr = vecs[i].next_addr;
            bus.jmpc      = vecs[i].jmpc;
            bus.jamn      = vecs[i].jamn;
            bus.jamz      = vecs[i].jamz;
            bus.alu_n     = vecs[i].alu_n;
            bus.alu_z     = vecs[i].alu_z;
            bus.mbr       = vecs[i].mbr;
            #1;
            check($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'h0);
            step();
            check($sformatf("vec%0d_mpc", i),  32'(bus.mpc),  32'(vecs[i].exp_mpc));
            check($sformatf("vec%0d_n_ff", i), 32'(bus.n_ff), 32'(vecs[i].exp_n));
            check($sformatf("vec%0d_z_ff", i), 32'(bus.z_ff), 32'(vecs[i].exp_z));
        end

        // JMPC waiting on an outstanding fetch
        idle_inputs();
        bus.fetch     = 1'b1;
        bus.next_addr = 9'h010;
        step();
        check("fetch_mpc", 32'(bus.mpc), 32'h010);
        bus.fetch     = 1'b0;
        bus.jmpc      = 1'b1;
        bus.next_addr = 9'h000;
        bus.mbr       = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("jmpc_stall%0d", i), 32'(bus.stall), 32'h1);
            bus.alu_n = 1'b1;
            step();
            check($sformatf("jmpc_hold_mpc%0d", i), 32'(bus.mpc),  32'h010);
            check($sformatf("jmpc_hold_n%0d", i),   32'(bus.n_ff), 32'h0);
        end
        bus.alu_n     = 1'b0;
        bus.mbr       = 8'h59;
        bus.mbr_valid = 1'b1;
        #1;
        check("jmpc_release_stall", 32'(bus.stall), 32'h0);
        step();
        check("jmpc_mbr_mpc", 32'(bus.mpc), 32'h059);

        // Pending cleared; new fetch, then set and clear in one cycle
        idle_inputs();
        bus.fetch     = 1'b1;
        bus.next_addr = 9'h030;
        #1;
        check("fetch_after_clear_stall", 32'(bus.stall), 32'h0);
        step();
        bus.mbr_valid = 1'b1;
        bus.next_addr = 9'h031;
        #1;
        check("set_clear_stall", 32'(bus.stall), 32'h0);
        step();
        check("set_clear_mpc", 32'(bus.mpc), 32'h031);
        idle_inputs();
        bus.jmpc = 1'b1;
        bus.mbr  = 8'h11;
        #1;
        check("pending_kept_stall", 32'(bus.stall), 32'h1);

        // Reset in the middle of a stall discards the fetch
        rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(bus.stall), 32'h0);
        step();
        check("rst_mid_stall_mpc", 32'(bus.mpc), 32'h000);
        rst = 1'b0;
        #1;
        check("fetch_discarded_stall", 32'(bus.stall), 32'h0);
        step();
        check("fetch_discarded_mpc", 32'(bus.mpc), 32'h011);

        // Illegal ALU code freezes the sequencer until reset
        idle_inputs();
        bus.next_addr = 9'h0AA;
        bus.alu_ctrl  = 6'b000000;
        step();
        check("illegal_err",   32'(bus.err),   32'h1);
        check("illegal_mpc",   32'(bus.mpc),   32'h011);
        check("illegal_stall", 32'(bus.stall), 32'h1);
        bus.alu_ctrl = 6'b011000;
        step();
        check("error_sticky_err", 32'(bus.err), 32'h1);
        check("error_sticky_mpc", 32'(bus.mpc), 32'h011);
        rst = 1'b1;
        step();
        check("error_rst_err", 32'(bus.err), 32'h0);
        check("error_rst_mpc", 32'(bus.mpc), 32'h000);
        rst = 1'b0;

        // Illegal code while stalled still traps
        bus.fetch     = 1'b1;
        bus.next_addr = 9'h040;
        step();
        bus.fetch    = 1'b0;
        bus.jmpc     = 1'b1;
        bus.alu_ctrl = 6'b111110;
        #1;
        check("prio_stall", 32'(bus.stall), 32'h1);
        step();
        check("prio_err", 32'(bus.err), 32'h1);
        check("prio_mpc", 32'(bus.mpc), 32'h040);
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;

        // Halt address behaviour depends on the build
        bus.next_addr = 9'h1FF;
        step();
        check("halt_mpc",    32'(bus.mpc),    32'h1FF);
        check("halt_halted", 32'(bus.halted), 32'(HALT_EN));
        bus.next_addr = 9'h005;
        #1;
        check("halt_stall", 32'(bus.stall), 32'(HALT_EN));
        step();
        check("halt_next_mpc",    32'(bus.mpc),    HALT_EN ? 32'h1FF : 32'h005);
        check("halt_next_halted", 32'(bus.halted), 32'(HALT_EN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mic1_sequencer
`default_nettype wire

// File: doc/mic1_sequencer.md
MIC1_SEQUENCER -- requirements
Module: mic1_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Clock and reset are the first two ports.
REQ-002 Parameter RESET_MPC SHALL default to 9'h000 and give the microaddress loaded on reset.
REQ-003 Parameter HALT_ADDR SHALL default to 9'h1FF and give the halt microaddress (used only when MIC1_SEQ_HALT_EN is defined).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 next_addr  in  9  NEXT_ADDRESS field of the current microinstruction.
REQ-007 jmpc / jamn / jamz  in  1 each  jump bits of the current microinstruction.
REQ-008 alu_ctrl  in  6  {F0,F1,ENA,ENB,INVA,INC} of the current microinstruction.
REQ-009 alu_n / alu_z  in  1 each  N and Z flags from the ALU in the current cycle.
REQ-010 fetch  in  1  current microinstruction issues an MBR fetch.
REQ-011 mbr  in  8  memory byte register; valid while mbr_valid=1.
REQ-012 mbr_valid  in  1  single-cycle pulse: the outstanding fetch has completed.
REQ-013 mpc  out  9  registered microprogram counter, used to address the control store.
REQ-014 n_ff / z_ff  out  1 each  latched ALU flags.
REQ-015 stall  out  1  combinational; the datapath must not commit this cycle.
REQ-016 halted / err  out  1 each  halt and illegal-ALU-code status.

Function
REQ-017 The FSM SHALL have the states RUN, STALL, HALT and ERROR.
REQ-018 In RUN with no stall, the next MPC SHALL be computed as follows:
- bit 8 = next_addr[8] | (jamn & alu_n) | (jamz & alu_z)
- bits 7:0 = next_addr[7:0] | (jmpc ? mbr : 8'h00)
REQ-019 In RUN with no stall, mpc SHALL load the next MPC at the clock edge, and n_ff and z_ff SHALL load alu_n and alu_z at the same edge.
REQ-020 pending SHALL be set at an edge where fetch=1 is accepted (stall=0). It SHALL be cleared at an edge where mbr_valid=1. Set and clear in the same cycle SHALL leave pending set.
REQ-021 stall SHALL be 1 when (jmpc | fetch) & pending & !mbr_valid.
REQ-022 While stall=1, the state SHALL be STALL, and mpc, n_ff and z_ff SHALL hold.
REQ-023 The state SHALL return to RUN in the cycle after mbr_valid; the held microinstruction then completes.
REQ-024 If jmpc=1 and mbr_valid=1 in the same cycle, the sequencer SHALL use mbr with no stall.
REQ-025 alu_ctrl SHALL be legal only if it is one of these 16 codes: 011000, 010100, 011010, 101100, 111100, 111101, 111001, 110101, 111111, 110110, 111011, 001100, 011100, 010000, 110001, 110010.
REQ-026 In RUN or STALL, an illegal alu_ctrl SHALL move the FSM to ERROR at the next edge and set err=1.
REQ-027 In ERROR, mpc, n_ff and z_ff SHALL hold, stall SHALL be 1, and only rst SHALL exit the state.
REQ-028 The illegal-code check SHALL take priority over a stall.
REQ-029 In HALT, mpc SHALL hold, stall SHALL be 1, and halted SHALL be 1; only rst SHALL exit the state.

Reset
REQ-030 On rst, mpc SHALL be RESET_MPC; n_ff, z_ff, pending, halted and err SHALL be 0; and the state SHALL be RUN.
REQ-031 rst SHALL override every other input in the same cycle, including reset mid-stall or mid-fetch. Any outstanding fetch SHALL be discarded.
REQ-032 stall SHALL be 0 in the cycle in which rst is asserted.

Configuration
REQ-033 When MIC1_SEQ_HALT_EN is defined, a RUN-state edge that loads mpc=HALT_ADDR SHALL move the FSM to HALT.
REQ-034 When MIC1_SEQ_HALT_EN is undefined, HALT SHALL be unreachable, halted SHALL be tied 0, and HALT_ADDR SHALL be an ordinary address.

Structure
REQ-035 The shared package mic1_pkg SHALL hold:
- the ALU control-code enum (the 16 codes)
- the sequencer state enum
- MPC_W=9 and MBR_W=8
REQ-036 Legality decoding SHALL be in a sub-module named mic1_alu_ctrl_check: alu_ctrl in, legal out, purely combinational.

Verification
REQ-037 Reset: assert rst with next_addr=9'h055 -> mpc=9'h000 and status outputs 0; release rst -> next cycle mpc=9'h055.
REQ-038 JAMZ: next_addr=9'h012, jamz=1, alu_z=1 -> mpc=9'h112 and z_ff=1; with alu_z=0 -> mpc=9'h012.
REQ-039 JMPC stall: fetch, then jmpc with next_addr=9'h000 while pending -> stall=1 and mpc held for 3 cycles; mbr=8'h59 with mbr_valid -> mpc=9'h059.
REQ-040 Illegal code: alu_ctrl=6'b000000 -> err=1 next cycle, mpc frozen; rst recovers.
REQ-041 Halt (MIC1_SEQ_HALT_EN defined): next_addr=9'h1FF -> halted=1, stall=1, mpc=9'h1FF held; same stimulus with the macro undefined -> halted=0 and sequencing continues.
